lsu_unit: RTL and testbench

- Load/store unit directly downstream of the execute-stage ALU.
- Consumes the ALU result as the effective address and rs2 as store data.
- Runs a valid/ready transaction to data memory, with byte/half/word lane steering, load sign/zero extension and misalignment detection.
- Returns one response per accepted request to the writeback/hazard logic.

---
 rtl/lsu_unit.sv | 249 ++++++++++++++++++++++++
 tb/tb_lsu_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_unit.sv
// lsu_unit: load/store unit sitting behind the execute-stage ALU.
// Takes the ALU result as the effective address and rs2 as store data.
// Runs one valid/ready transaction to data memory per accepted op.
// Handles byte/half/word lane steering, load sign/zero extension and
// misalignment / illegal-funct3 detection.
// Returns exactly one RespValid pulse per accepted op.
//
// state | meaning
// IDLE  | ReqReady high, waiting for an op from execute
// REQ   | MemReqValid held with stable address/strobes/data until MemReqReady
// WAIT  | load issued, waiting (indefinitely) for MemRespValid
// DONE  | one-cycle RespValid with RespData and error flags
module lsu_unit #(
    parameter int WIDTH_DATA_LENGTH = 32,
    parameter int WIDTH_ADDR_LENGTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ReqValid,
    output logic                         ReqReady,
    input  logic                         MemRW,
    input  logic [2:0]                   Funct3,
    input  logic [WIDTH_ADDR_LENGTH-1:0] Addr,
    input  logic [WIDTH_DATA_LENGTH-1:0] StoreData,
    output logic                         MemReqValid,
    input  logic                         MemReqReady,
    output logic [WIDTH_ADDR_LENGTH-1:0] MemAddr,
    output logic                         MemWe,
    output logic [3:0]                   MemWStrb,
    output logic [WIDTH_DATA_LENGTH-1:0] MemWData,
    input  logic                         MemRespValid,
    input  logic [WIDTH_DATA_LENGTH-1:0] MemRData,
    output logic                         RespValid,
    output logic [WIDTH_DATA_LENGTH-1:0] RespData,
    output logic                         MisalignErr,
    output logic                         FunctErr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    // Latched op fields needed after the request has left IDLE.
    logic       op_store;
    logic [2:0] op_funct3;
    logic [1:0] op_offset;
    logic       latch_op;

    // Decode of the op currently presented by execute.
    logic                         funct_bad;
    logic                         addr_misaligned;
    logic [3:0]                   st_strb;
    logic [WIDTH_DATA_LENGTH-1:0] st_wdata;

    // Load lane extraction from the returned word.
    logic [7:0]                   ld_byte;
    logic [15:0]                  ld_half;
    logic [WIDTH_DATA_LENGTH-1:0] ld_result;

    // Next values of the registered outputs.
    logic                         mem_req_valid_nx;
    logic [WIDTH_ADDR_LENGTH-1:0] mem_addr_nx;
    logic                         mem_we_nx;
    logic [3:0]                   mem_wstrb_nx;
    logic [WIDTH_DATA_LENGTH-1:0] mem_wdata_nx;
    logic                         resp_valid_nx;
    logic [WIDTH_DATA_LENGTH-1:0] resp_data_nx;
    logic                         misalign_nx;
    logic                         funct_nx;

    // Only accept in IDLE, and never while reset is being applied.
    assign ReqReady = (state == ST_IDLE) && rst_n;

    // Classify funct3: stores allow SB/SH/SW only, loads also LBU/LHU.
    always_comb begin
        funct_bad = 1'b0;
        if (MemRW) begin
            funct_bad = Funct3[2] || (Funct3[1:0] == 2'b11);
        end else begin
            funct_bad = (Funct3 == 3'b011) || (Funct3 == 3'b110) ||
                        (Funct3 == 3'b111);
        end
    end

    // Alignment check keyed on access size (funct3[1:0]).
    always_comb begin
        addr_misaligned = 1'b0;
        case (Funct3[1:0])
            2'b01:   addr_misaligned = Addr[0];
            2'b10:   addr_misaligned = |Addr[1:0];
            default: addr_misaligned = 1'b0;
        endcase
    end

    // Store lane steering: data replicated across lanes, strobes pick the lane.
    always_comb begin
        st_strb  = 4'b1111;
        st_wdata = StoreData;
        case (Funct3[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << Addr[1:0];
                st_wdata = {4{StoreData[7:0]}};
            end
            2'b01: begin
                st_strb  = Addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{StoreData[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = StoreData;
            end
        endcase
    end

    // Load lane select and extension using the latched offset and funct3.
    always_comb begin
        ld_byte = MemRData[7:0];
        case (op_offset)
            2'd0:    ld_byte = MemRData[7:0];
            2'd1:    ld_byte = MemRData[15:8];
            2'd2:    ld_byte = MemRData[23:16];
            default: ld_byte = MemRData[31:24];
        endcase
        ld_half = op_offset[1] ? MemRData[31:16] : MemRData[15:0];
        case (op_funct3)
            3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_result = {24'd0, ld_byte};
            3'b101:  ld_result = {16'd0, ld_half};
            default: ld_result = MemRData;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_nx         = state;
        latch_op         = 1'b0;
        mem_req_valid_nx = MemReqValid;
        mem_addr_nx      = MemAddr;
        mem_we_nx        = MemWe;
        mem_wstrb_nx     = MemWStrb;
        mem_wdata_nx     = MemWData;
        resp_valid_nx    = 1'b0;
        resp_data_nx     = '0;
        misalign_nx      = 1'b0;
        funct_nx         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ReqValid && ReqReady) begin
                    latch_op = 1'b1;
                    if (funct_bad) begin
                        state_nx      = ST_DONE;
                        resp_valid_nx = 1'b1;
                        funct_nx      = 1'b1;
                    end else if (addr_misaligned) begin
                        state_nx      = ST_DONE;
                        resp_valid_nx = 1'b1;
                        misalign_nx   = 1'b1;
                    end else begin
                        state_nx         = ST_REQ;
                        mem_req_valid_nx = 1'b1;
                        mem_addr_nx      = {Addr[WIDTH_ADDR_LENGTH-1:2], 2'b00};
                        mem_we_nx        = MemRW;
                        mem_wstrb_nx     = MemRW ? st_strb : 4'b0000;
                        mem_wdata_nx     = MemRW ? st_wdata : '0;
                    end
                end
            end
            ST_REQ: begin
                if (MemReqReady) begin
                    mem_req_valid_nx = 1'b0;
                    // Drop the write qualifiers once the beat is taken so no
                    // stale strobe lingers next to a deasserted valid.
                    mem_we_nx        = 1'b0;
                    mem_wstrb_nx     = 4'b0000;
                    mem_wdata_nx     = '0;
                    if (op_store) begin
                        state_nx      = ST_DONE;
                        resp_valid_nx = 1'b1;
                    end else begin
                        state_nx = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (MemRespValid) begin
                    state_nx      = ST_DONE;
                    resp_valid_nx = 1'b1;
                    resp_data_nx  = ld_result;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Output and op-latch registers; reset abandons any pending transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            MemReqValid <= 1'b0;
            MemAddr     <= '0;
            MemWe       <= 1'b0;
            MemWStrb    <= 4'b0000;
            MemWData    <= '0;
            RespValid   <= 1'b0;
            RespData    <= '0;
            MisalignErr <= 1'b0;
            FunctErr    <= 1'b0;
            op_store    <= 1'b0;
            op_funct3   <= 3'b000;
            op_offset   <= 2'b00;
        end else begin
            MemReqValid <= mem_req_valid_nx;
            MemAddr     <= mem_addr_nx;
            MemWe       <= mem_we_nx;
            MemWStrb    <= mem_wstrb_nx;
            MemWData    <= mem_wdata_nx;
            RespValid   <= resp_valid_nx;
            RespData    <= resp_data_nx;
            MisalignErr <= misalign_nx;
            FunctErr    <= funct_nx;
            if (latch_op) begin
                op_store  <= MemRW;
                op_funct3 <= Funct3;
                op_offset <= Addr[1:0];
            end
        end
    end

endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: directed bench for lsu_unit. Expected responses are queued
// when an op is driven and compared by a monitor whenever RespValid pulses.
module tb_lsu_unit;

    logic        clk;
    logic        rst_n;
    logic        ReqValid;
    logic        ReqReady;
    logic        MemRW;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] StoreData;
    logic        MemReqValid;
    logic        MemReqReady;
    logic [31:0] MemAddr;
    logic        MemWe;
    logic [3:0]  MemWStrb;
    logic [31:0] MemWData;
    logic        MemRespValid;
    logic [31:0] MemRData;
    logic        RespValid;
    logic [31:0] RespData;
    logic        MisalignErr;
    logic        FunctErr;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        logic        fun;
    } exp_t;

    exp_t sb[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   resp_seen = 0;

    lsu_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ReqValid     (ReqValid),
        .ReqReady     (ReqReady),
        .MemRW        (MemRW),
        .Funct3       (Funct3),
        .Addr         (Addr),
        .StoreData    (StoreData),
        .MemReqValid  (MemReqValid),
        .MemReqReady  (MemReqReady),
        .MemAddr      (MemAddr),
        .MemWe        (MemWe),
        .MemWStrb     (MemWStrb),
        .MemWData     (MemWData),
        .MemRespValid (MemRespValid),
        .MemRData     (MemRData),
        .RespValid    (RespValid),
        .RespData     (RespData),
        .MisalignErr  (MisalignErr),
        .FunctErr     (FunctErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic m, input logic f);
        exp_t e;
        e.data = d;
        e.mis  = m;
        e.fun  = f;
        sb.push_back(e);
    endtask

    // Compare every response pulse against the oldest queued expectation.
    always @(negedge clk) begin
        if (RespValid === 1'b1) begin
            exp_t e;
            resp_seen++;
            check("resp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("resp_data", RespData, e.data);
                check("resp_misalign", 32'(MisalignErr), 32'(e.mis));
                check("resp_functerr", 32'(FunctErr), 32'(e.fun));
            end
        end
    end

    // Present an op for exactly one accepting edge; returns in cycle 1.
    task automatic issue(input logic rw, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd);
        ReqValid  = 1'b1;
        MemRW     = rw;
        Funct3    = f3;
        Addr      = a;
        StoreData = sd;
        @(posedge clk); #1;
        ReqValid = 1'b0;
    endtask

    task automatic load_zw(input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rdata, input logic [31:0] exp);
        MemReqReady = 1'b1;
        push(exp, 1'b0, 1'b0);
        issue(1'b0, f3, a, 32'h0);
        @(negedge clk);
        check("ld_req_valid_c1", 32'(MemReqValid), 32'd1);
        check("ld_mem_addr", MemAddr, {a[31:2], 2'b00});
        check("ld_mem_we", 32'(MemWe), 32'd0);
        check("ld_mem_wstrb", 32'(MemWStrb), 32'd0);
        @(posedge clk); #1;
        MemRespValid = 1'b1;
        MemRData     = rdata;
        @(negedge clk);
        check("ld_req_valid_c2", 32'(MemReqValid), 32'd0);
        check("ld_resp_early", 32'(RespValid), 32'd0);
        @(posedge clk); #1;
        MemRespValid = 1'b0;
        MemRData     = 32'h0;
        @(negedge clk);
        check("ld_resp_c3", 32'(RespValid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("ld_resp_one_cycle", 32'(RespValid), 32'd0);
        check("ld_ready_after", 32'(ReqReady), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic store_zw(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                            input logic [3:0] strb, input logic [31:0] wdata);
        MemReqReady = 1'b1;
        push(32'h0, 1'b0, 1'b0);
        issue(1'b1, f3, a, sd);
        @(negedge clk);
        check("st_req_valid", 32'(MemReqValid), 32'd1);
        check("st_mem_we", 32'(MemWe), 32'd1);
        check("st_mem_addr", MemAddr, {a[31:2], 2'b00});
        check("st_mem_wstrb", 32'(MemWStrb), 32'(strb));
        check("st_mem_wdata", MemWData, wdata);
        @(posedge clk); #1;
        @(negedge clk);
        check("st_resp_c2", 32'(RespValid), 32'd1);
        check("st_req_dropped", 32'(MemReqValid), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic err_op(input logic rw, input logic [2:0] f3, input logic [31:0] a,
                          input logic mis, input logic fun);
        MemReqReady = 1'b1;
        push(32'h0, mis, fun);
        issue(rw, f3, a, 32'hFFFF_FFFF);
        @(negedge clk);
        check("err_no_mem_req", 32'(MemReqValid), 32'd0);
        check("err_resp_c1", 32'(RespValid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("err_resp_cleared", 32'(RespValid), 32'd0);
        check("err_flags_cleared", 32'({MisalignErr, FunctErr}), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        rst_n        = 1'b0;
        ReqValid     = 1'b0;
        MemRW        = 1'b0;
        Funct3       = 3'b000;
        Addr         = 32'h0;
        StoreData    = 32'h0;
        MemReqReady  = 1'b0;
        MemRespValid = 1'b0;
        MemRData     = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(ReqReady), 32'd0);
        check("rst_mem_req_valid", 32'(MemReqValid), 32'd0);
        check("rst_mem_addr", MemAddr, 32'h0);
        check("rst_mem_wstrb", 32'(MemWStrb), 32'd0);
        check("rst_resp", 32'({RespValid, MisalignErr, FunctErr}), 32'd0);
        check("rst_resp_data", RespData, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 32'(ReqReady), 32'd1);
        @(posedge clk); #1;

        // Loads with lane extraction
        load_zw(3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        load_zw(3'b000, 32'h0000_1003, 32'h80FF_0000, 32'hFFFF_FF80);
        load_zw(3'b100, 32'h0000_1003, 32'h80FF_0000, 32'h0000_0080);
        load_zw(3'b101, 32'h0000_1002, 32'h80FF_0000, 32'h0000_80FF);
        load_zw(3'b001, 32'h0000_1000, 32'h1234_8001, 32'hFFFF_8001);
        load_zw(3'b000, 32'h0000_1001, 32'h0000_7F00, 32'h0000_007F);
        load_zw(3'b001, 32'h0000_1002, 32'h7654_0000, 32'h0000_7654);

        // SB with memory back-pressure for three cycles
        MemReqReady = 1'b0;
        push(32'h0, 1'b0, 1'b0);
        issue(1'b1, 3'b000, 32'h0000_2001, 32'h1234_56AB);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("sb_req_valid_hold", 32'(MemReqValid), 32'd1);
            check("sb_mem_addr", MemAddr, 32'h0000_2000);
            check("sb_mem_wstrb", 32'(MemWStrb), 32'b0010);
            check("sb_mem_wdata", MemWData, 32'hABAB_ABAB);
            check("sb_no_resp_yet", 32'(RespValid), 32'd0);
            @(posedge clk); #1;
            if (i == 2) MemReqReady = 1'b1;
        end
        @(negedge clk);
        check("sb_resp", 32'(RespValid), 32'd1);
        check("sb_req_dropped", 32'(MemReqValid), 32'd0);
        @(posedge clk); #1;

        // Zero-wait stores
        store_zw(3'b001, 32'h0000_2002, 32'hCAFE_BEEF, 4'b1100, 32'hBEEF_BEEF);
        store_zw(3'b001, 32'h0000_2000, 32'hCAFE_1234, 4'b0011, 32'h1234_1234);
        store_zw(3'b010, 32'h0000_2008, 32'h0123_4567, 4'b1111, 32'h0123_4567);
        store_zw(3'b000, 32'h0000_200F, 32'h0000_0055, 4'b1000, 32'h5555_5555);

        // Misalignment and illegal funct3
        err_op(1'b0, 3'b010, 32'h0000_3002, 1'b1, 1'b0);
        err_op(1'b0, 3'b101, 32'h0000_3001, 1'b1, 1'b0);
        err_op(1'b1, 3'b010, 32'h0000_3001, 1'b1, 1'b0);
        err_op(1'b0, 3'b011, 32'h0000_3000, 1'b0, 1'b1);
        err_op(1'b0, 3'b110, 32'h0000_3000, 1'b0, 1'b1);
        err_op(1'b1, 3'b100, 32'h0000_3000, 1'b0, 1'b1);
        err_op(1'b1, 3'b101, 32'h0000_3001, 1'b0, 1'b1);

        // Reset while waiting for load data; late response is dropped
        MemReqReady = 1'b1;
        issue(1'b0, 3'b010, 32'h0000_4000, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("wait_rst_ready_low", 32'(ReqReady), 32'd0);
        @(posedge clk); #1;
        rst_n        = 1'b1;
        MemRespValid = 1'b1;
        MemRData     = 32'h9999_9999;
        @(negedge clk);
        check("wait_rst_ready", 32'(ReqReady), 32'd1);
        check("wait_rst_no_resp", 32'(RespValid), 32'd0);
        check("wait_rst_mem_addr", MemAddr, 32'h0);
        @(posedge clk); #1;
        MemRespValid = 1'b0;
        @(negedge clk);
        check("wait_rst_ignored_resp", 32'(RespValid), 32'd0);
        @(posedge clk); #1;

        // Reset while MemReqValid is stalled; it drops without a handshake
        MemReqReady = 1'b0;
        issue(1'b1, 3'b010, 32'h0000_4100, 32'h1111_1111);
        rst_n = 1'b0;
        @(negedge clk);
        check("req_rst_valid_before", 32'(MemReqValid), 32'd1);
        @(posedge clk); #1;
        rst_n       = 1'b1;
        MemReqReady = 1'b1;
        @(negedge clk);
        check("req_rst_valid_dropped", 32'(MemReqValid), 32'd0);
        check("req_rst_wstrb", 32'(MemWStrb), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("req_rst_no_resp", 32'(RespValid), 32'd0);
        @(posedge clk); #1;

        // Stray response in IDLE, then a second op held during a busy load
        MemRespValid = 1'b1;
        MemRData     = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        MemRespValid = 1'b0;
        @(negedge clk);
        check("stray_no_resp", 32'(RespValid), 32'd0);
        check("stray_ready", 32'(ReqReady), 32'd1);
        @(posedge clk); #1;
        base        = resp_seen;
        MemReqReady = 1'b1;
        push(32'h1111_2222, 1'b0, 1'b0);
        push(32'h0, 1'b0, 1'b0);
        ReqValid = 1'b1;
        MemRW    = 1'b0;
        Funct3   = 3'b010;
        Addr     = 32'h0000_5000;
        @(posedge clk); #1;
        MemRW     = 1'b1;
        Addr      = 32'h0000_5004;
        StoreData = 32'hA5A5_A5A5;
        @(negedge clk);
        check("hold_busy_c1", 32'(ReqReady), 32'd0);
        check("hold_first_is_load", 32'(MemWe), 32'd0);
        @(posedge clk); #1;
        MemRespValid = 1'b1;
        MemRData     = 32'h1111_2222;
        @(negedge clk);
        check("hold_busy_c2", 32'(ReqReady), 32'd0);
        @(posedge clk); #1;
        MemRespValid = 1'b0;
        @(negedge clk);
        check("hold_busy_done", 32'(ReqReady), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_ready_after_done", 32'(ReqReady), 32'd1);
        @(posedge clk); #1;
        ReqValid = 1'b0;
        @(negedge clk);
        check("hold_second_req", 32'(MemReqValid), 32'd1);
        check("hold_second_we", 32'(MemWe), 32'd1);
        check("hold_second_addr", MemAddr, 32'h0000_5004);
        check("hold_second_wdata", MemWData, 32'hA5A5_A5A5);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_two_responses", 32'(resp_seen - base), 32'd2);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
